// File: rtl/sap1_fetch_unit_pkg.sv
// Shared constants for the SAP-1 fetch stage: opcodes, one-hot T-states,
// default widths and a one-hot integrity helper.
package sap1_fetch_unit_pkg;

  localparam int SAP1_ADDR_W = 4;
  localparam int SAP1_DATA_W = 8;

  // Opcodes (upper nibble of the instruction word)
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // One-hot T-states, bit0 = T1 ... bit5 = T6
  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  // True when exactly one bit of the ring is set.
  function automatic logic onehot6(input logic [5:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 6; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return (cnt == 3'd1);
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-phase one-hot ring counter with synchronous clear and enable.
// A ring found holding a non one-hot pattern re-enters at T1 on its
// next enabled edge instead of circulating the corrupt pattern.
module sap1_ring_counter
  import sap1_fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  output logic [5:0] state
);

  // Ring register: clear to T1, rotate left when enabled, otherwise hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= T1;
    end else if (en) begin
      if (onehot6(state)) begin
        state <= {state[4:0], state[5]};
      end else begin
        state <= T1;
      end
    end else begin
      state <= state;
    end
  end

endmodule

// File: rtl/sap1_fetch_unit.sv
// SAP-1 instruction-fetch stage: program counter, MAR, IR and T-state ring.
// Optional feature macro: SAP1_JMP_EN (opcode JMP loads PC at the end of T4).
module sap1_fetch_unit
  import sap1_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = SAP1_ADDR_W,
  parameter int DATA_W = SAP1_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic              mar_ld,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] mar_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] ir_out,
  output logic [5:0]        t_state,
  output logic              halt
);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] mar_r;
  logic [DATA_W-1:0] ir_r;
  logic              halt_r;

  logic [ADDR_W-1:0] pc_s;
  logic [ADDR_W-1:0] mar_s;
  logic [DATA_W-1:0] ir_s;
  logic              halt_s;

  logic [3:0]        opcode_s;
  logic [ADDR_W-1:0] operand_s;
  logic              advance_s;
  logic              hlt_in_t4_s;
  logic              ring_en_s;

  assign opcode_s    = ir_r[DATA_W-1 -: 4];
  assign operand_s   = ir_r[ADDR_W-1:0];
  assign advance_s   = run & ~halt_r;
  assign hlt_in_t4_s = (t_state == T4) && (opcode_s == OP_HLT);
  // The ring stops on T4 of a HLT so the halted machine reports T4.
  assign ring_en_s   = advance_s & ~hlt_in_t4_s;

  sap1_ring_counter u_ring (
    .clk   (clk),
    .clr   (clr),
    .en    (ring_en_s),
    .state (t_state)
  );

  // Next-state of PC/MAR/IR/halt: actions taken at the edge ending each phase.
  always_comb begin
    pc_s   = pc_r;
    mar_s  = mar_r;
    ir_s   = ir_r;
    halt_s = halt_r;
    if (advance_s) begin
      case (t_state)
        T1: mar_s = pc_r;
        T2: pc_s  = pc_r + ADDR_W'(1);
        T3: ir_s  = rom_data;
        T4: begin
          if (mar_ld) begin
            mar_s = operand_s;
          end else begin
            mar_s = mar_r;
          end
          if (opcode_s == OP_HLT) begin
            halt_s = 1'b1;
          end else begin
            halt_s = halt_r;
          end
`ifdef SAP1_JMP_EN
          if (opcode_s == OP_JMP) begin
            pc_s = operand_s;
          end else begin
            pc_s = pc_r;
          end
`else
          pc_s = pc_r;
`endif
        end
        default: begin
          pc_s   = pc_r;
          mar_s  = mar_r;
          ir_s   = ir_r;
          halt_s = halt_r;
        end
      endcase
    end else begin
      pc_s   = pc_r;
      mar_s  = mar_r;
      ir_s   = ir_r;
      halt_s = halt_r;
    end
  end

  // Architectural registers with synchronous clear that overrides everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_r   <= {ADDR_W{1'b0}};
      mar_r  <= {ADDR_W{1'b0}};
      ir_r   <= {DATA_W{1'b0}};
      halt_r <= 1'b0;
    end else begin
      pc_r   <= pc_s;
      mar_r  <= mar_s;
      ir_r   <= ir_s;
      halt_r <= halt_s;
    end
  end

  assign pc_out  = pc_r;
  assign mar_out = mar_r;
  assign ir_out  = ir_r;
  assign halt    = halt_r;

endmodule

// File: tb/tb_sap1_fetch_unit.sv
// Directed, table-driven bench for sap1_fetch_unit with a behavioural ROM.
module tb_sap1_fetch_unit;

  logic       clk = 1'b0;
  logic       clr;
  logic       run;
  logic       mar_ld;
  logic [7:0] rom_data;
  logic [3:0] mar_out;
  logic [3:0] pc_out;
  logic [7:0] ir_out;
  logic [5:0] t_state;
  logic       halt;

  logic [7:0] rom [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       clr;
    logic       run;
    logic       mar_ld;
    logic [3:0] pc;
    logic [3:0] mar;
    logic [7:0] ir;
    logic [5:0] t;
    logic       halt;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  assign rom_data = rom[mar_out];

  sap1_fetch_unit #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk      (clk),
    .clr      (clr),
    .run      (run),
    .mar_ld   (mar_ld),
    .rom_data (rom_data),
    .mar_out  (mar_out),
    .pc_out   (pc_out),
    .ir_out   (ir_out),
    .t_state  (t_state),
    .halt     (halt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] pc, input logic [3:0] mar,
                       input logic [7:0] ir, input logic [5:0] t, input logic h);
    checks++;
    if (pc_out !== pc || mar_out !== mar || ir_out !== ir || t_state !== t || halt !== h) begin
      errors++;
      $display("FAIL %s: got pc=%h mar=%h ir=%h t=%b halt=%b, expected pc=%h mar=%h ir=%h t=%b halt=%b",
               name, pc_out, mar_out, ir_out, t_state, halt, pc, mar, ir, t, h);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic r, input logic m, input logic [3:0] pc,
                              input logic [3:0] mar, input logic [7:0] ir, input logic [5:0] t,
                              input logic h);
    vec_t v;
    v.clr = c; v.run = r; v.mar_ld = m;
    v.pc = pc; v.mar = mar; v.ir = ir; v.t = t; v.halt = h;
    return v;
  endfunction

  initial begin
    logic [3:0] jmp_pc;
    clr = 1'b1; run = 1'b0; mar_ld = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'hE0;
    rom[0] = 8'h1A;
    rom[1] = 8'hF0;

    // Fetch of 8'h1A with MAR load in T4, then HLT with MAR load, then halted, then clear.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 6'b000001, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 6'b000010, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h1, 4'h0, 8'h00, 6'b000100, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h1, 4'h0, 8'h1A, 6'b001000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h1, 4'hA, 8'h1A, 6'b010000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h1, 4'hA, 8'h1A, 6'b100000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h1, 4'hA, 8'h1A, 6'b000001, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h1, 4'h1, 8'h1A, 6'b000010, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h2, 4'h1, 8'h1A, 6'b000100, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h2, 4'h1, 8'hF0, 6'b001000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h2, 4'h0, 8'hF0, 6'b001000, 1'b1));
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk(1'b0, 1'b1, logic'(i % 2), 4'h2, 4'h0, 8'hF0, 6'b001000, 1'b1));
    end
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 8'h00, 6'b000001, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      clr = vecs[i].clr; run = vecs[i].run; mar_ld = vecs[i].mar_ld;
      step();
      check($sformatf("vec%0d", i), vecs[i].pc, vecs[i].mar, vecs[i].ir, vecs[i].t, vecs[i].halt);
    end

    // Reset in the middle of T3.
    clr = 1'b0; run = 1'b1; mar_ld = 1'b0;
    step(); step();
    check("pre_reset_t3", 4'h1, 4'h0, 8'h00, 6'b000100, 1'b0);
    clr = 1'b1;
    step();
    check("reset_mid_t3", 4'h0, 4'h0, 8'h00, 6'b000001, 1'b0);
    clr = 1'b0;

    // Stall for three cycles during T2.
    step();
    check("stall_enter_t2", 4'h0, 4'h0, 8'h00, 6'b000010, 1'b0);
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_hold%0d", i), 4'h0, 4'h0, 8'h00, 6'b000010, 1'b0);
    end
    run = 1'b1;
    step();
    check("stall_resume_t2", 4'h1, 4'h0, 8'h00, 6'b000100, 1'b0);
    step();
    check("stall_resume_t3", 4'h1, 4'h0, 8'h1A, 6'b001000, 1'b0);

    // PC wrap after fifteen OUT instructions.
    for (int i = 0; i < 16; i++) rom[i] = 8'hE0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 90; i++) step();
    check("wrap_pc15", 4'hF, 4'hE, 8'hE0, 6'b000001, 1'b0);
    step();
    check("wrap_t1", 4'hF, 4'hF, 8'hE0, 6'b000010, 1'b0);
    step();
    check("wrap_pc0", 4'h0, 4'hF, 8'hE0, 6'b000100, 1'b0);

    // JMP 5 at address 0.
`ifdef SAP1_JMP_EN
    jmp_pc = 4'h5;
`else
    jmp_pc = 4'h1;
`endif
    rom[0] = 8'h65;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("jmp_after_t4", jmp_pc, 4'h0, 8'h65, 6'b010000, 1'b0);
    for (int i = 0; i < 3; i++) step();
    check("jmp_next_fetch", jmp_pc, jmp_pc, 8'h65, 6'b000010, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
